// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch sequencer.
// It requests one 9-bit instruction at a time from instruction memory and
// latches it into instr_out/pc_out. It strobes ir_we for one cycle and then
// holds the instruction until the core advances or redirects. A fetch that
// waits too long for imem_ready parks the unit in a sticky error state that
// only rst leaves.
module fetch_unit #(
    parameter int RESET_PC = 0,
    parameter int PC_W     = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_rdata,
    input  logic            imem_ready,
    input  logic            advance,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    output logic            ir_we,
    output logic [8:0]      instr_out,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_err
);

    // The wait counter must be able to hold TIMEOUT itself, because it saturates there.
    localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [PC_W-1:0]   RST_PC  = PC_W'(RESET_PC);
    localparam logic [WCNT_W-1:0] TO_MAX  = WCNT_W'(TIMEOUT);
    // The last stall cycle is the one where the counter already shows TIMEOUT-1.
    // Its increment makes the count TIMEOUT, so the state moves to ERR on the same edge.
    localparam logic [WCNT_W-1:0] TO_LAST = (TIMEOUT < 1) ? '0 : WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DELIVER = 3'd2,
        HOLD    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_nxt;
    logic [WCNT_W-1:0] wait_cnt;

    // Side effects that the next-state logic requests from the datapath registers.
    logic capture;
    logic cnt_clr;
    logic cnt_inc;
    logic err_set;

    // Saturating increment for the stall counter.
    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        if (v >= TO_MAX) begin
            return TO_MAX;
        end
        return v + 1'b1;
    endfunction

    // The address bus always shows pc. The bus has meaning only while imem_req is high.
    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, memory and IR strobes, and datapath update requests.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        err_set   = 1'b0;
        imem_req  = 1'b0;
        ir_we     = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
                cnt_clr   = 1'b1;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (branch_valid) begin
                    // A redirect discards any response in the same cycle.
                    // The fetch then restarts at the target with a fresh stall count.
                    pc_nxt  = branch_target;
                    cnt_clr = 1'b1;
                end else if (imem_ready) begin
                    capture   = 1'b1;
                    state_nxt = DELIVER;
                end else begin
                    cnt_inc = 1'b1;
                    if (wait_cnt >= TO_LAST) begin
                        state_nxt = ERR;
                        err_set   = 1'b1;
                    end
                end
            end

            DELIVER: begin
                ir_we = 1'b1;
                if (branch_valid) begin
                    pc_nxt    = branch_target;
                    cnt_clr   = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                // A redirect wins over a same-cycle advance.
                if (branch_valid) begin
                    pc_nxt    = branch_target;
                    cnt_clr   = 1'b1;
                    state_nxt = FETCH;
                end else if (advance) begin
                    pc_nxt    = pc + 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = FETCH;
                end
            end

            ERR: begin
                state_nxt = ERR;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RST_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // Fetch stall counter: it is cleared whenever FETCH is entered and saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (cnt_clr) begin
            wait_cnt <= '0;
        end else if (cnt_inc) begin
            wait_cnt <= sat_inc(wait_cnt);
        end
    end

    // Instruction register and the address that goes with it.
    // These registers hold their value through DELIVER and HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out <= '0;
            pc_out    <= RST_PC;
        end else if (capture) begin
            instr_out <= imem_rdata;
            pc_out    <= pc;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (err_set) begin
            fetch_err <= 1'b1;
        end
    end

endmodule
